// File: rtl/psqwg_multi_pkg.sv
// Shared types and parameter helpers for the multi-channel square-wave generator.
// Holds the channel FSM encoding and the clocks-per-unit derivation.
package psqwg_multi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HIGH = 2'b01,
        ST_LOW  = 2'b10
    } state_e;

    function automatic int div_of(input int t, input int unit_ns);
        return unit_ns / t;
    endfunction

    // Phase counter must hold the longest phase without wrapping.
    function automatic bit cfg_legal(
        input int t,
        input int unit_ns,
        input int m_bits,
        input int n_bits,
        input int cnt_bits
    );
        int d;
        int mx;
        d  = unit_ns / t;
        mx = ((1 << m_bits) > (1 << n_bits)) ?
             (1 << m_bits) - 1 : (1 << n_bits) - 1;
        return (unit_ns % t == 0) && (d > 0) &&
               ((1 << cnt_bits) > mx * d);
    endfunction

endpackage

// File: rtl/psqwg_multi_if.sv
// Bundled per-channel control and output buses of psqwg_multi.
// The generator sits on the slave side; the controller drives the master side.
interface psqwg_multi_if #(
    parameter int CH         = 4,
    parameter int M_BITS     = 4,
    parameter int N_BITS     = 4,
    parameter int BURST_BITS = 8
);
    logic [CH-1:0]            en;
    logic [CH-1:0]            cfg_we;
    logic [CH*M_BITS-1:0]     m;
    logic [CH*N_BITS-1:0]     n;
    logic [CH*BURST_BITS-1:0] burst;
    logic [CH-1:0]            sq_wave;
    logic [CH-1:0]            busy;
    logic [CH-1:0]            done;

    modport master (
        output en, cfg_we, m, n, burst,
        input  sq_wave, busy, done
    );

    modport slave (
        input  en, cfg_we, m, n, burst,
        output sq_wave, busy, done
    );
endinterface

// File: rtl/psqwg_multi_chan.sv
// One generator channel: shadow/active config, phase and burst counters,
// and the IDLE/HIGH/LOW FSM with registered outputs.
module psqwg_chan
    import psqwg_multi_pkg::*;
#(
    parameter int DIV          = 5,
    parameter int M_BITS       = 4,
    parameter int N_BITS       = 4,
    parameter int BURST_BITS   = 8,
    parameter int COUNTER_BITS = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic                  cfg_we_i,
    input  logic [M_BITS-1:0]     m_i,
    input  logic [N_BITS-1:0]     n_i,
    input  logic [BURST_BITS-1:0] burst_i,
    output logic                  sq_o,
    output logic                  busy_o,
    output logic                  done_o
);
    localparam logic [COUNTER_BITS-1:0] C_ONE = COUNTER_BITS'(1);
    localparam logic [COUNTER_BITS-1:0] C_DIV = COUNTER_BITS'(DIV);

    state_e                  state_q;
    logic [COUNTER_BITS-1:0] cnt_q;
    logic [BURST_BITS-1:0]   pcnt_q;
    logic [M_BITS-1:0]       sh_m_q, act_m_q;
    logic [N_BITS-1:0]       sh_n_q, act_n_q;
    logic [BURST_BITS-1:0]   sh_b_q, act_b_q;
    logic                    en_d1_q, en_d2_q;
    logic                    sq_q, done_q;

    logic [M_BITS-1:0]       eff_m;
    logic [N_BITS-1:0]       eff_n;
    logic [BURST_BITS-1:0]   eff_b;
    logic [COUNTER_BITS-1:0] m_last, n_last;
    logic [BURST_BITS-1:0]   pcnt_nx;
    logic                    rise, start_hi;
    logic                    hi_end, lo_end;
    logic                    bound, pend, fin;
    state_e                  st_start;

    // A write on the boundary cycle reaches the active set directly.
    assign eff_m = cfg_we_i ? m_i     : sh_m_q;
    assign eff_n = cfg_we_i ? n_i     : sh_n_q;
    assign eff_b = cfg_we_i ? burst_i : sh_b_q;

    assign m_last   = COUNTER_BITS'(act_m_q) * C_DIV - C_ONE;
    assign n_last   = COUNTER_BITS'(act_n_q) * C_DIV - C_ONE;
    assign pcnt_nx  = pcnt_q + BURST_BITS'(1);
    assign rise     = en_d1_q & ~en_d2_q & en_i;
    assign start_hi = (eff_m != '0);
    assign st_start = start_hi ? ST_HIGH : ST_LOW;

    assign hi_end = (state_q == ST_HIGH) && (cnt_q == m_last);
    assign lo_end = (state_q == ST_LOW) &&
                    ((act_n_q == '0) || (cnt_q == n_last));
    assign bound  = (hi_end && (act_n_q == '0)) || lo_end;
    // An all-zero period only reloads config; it never counts.
    assign pend   = bound && ((act_m_q != '0) || (act_n_q != '0));
    assign fin    = pend && (act_b_q != '0) && (pcnt_nx == act_b_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pcnt_q  <= '0;
            sh_m_q  <= '0;
            sh_n_q  <= '0;
            sh_b_q  <= '0;
            act_m_q <= '0;
            act_n_q <= '0;
            act_b_q <= '0;
            en_d1_q <= 1'b0;
            en_d2_q <= 1'b0;
            sq_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            en_d1_q <= en_i;
            en_d2_q <= en_d1_q;
            done_q  <= 1'b0;
            if (cfg_we_i) begin
                sh_m_q <= m_i;
                sh_n_q <= n_i;
                sh_b_q <= burst_i;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        act_m_q <= eff_m;
                        act_n_q <= eff_n;
                        act_b_q <= eff_b;
                        state_q <= st_start;
                        cnt_q   <= '0;
                        pcnt_q  <= '0;
                        sq_q    <= start_hi;
                    end
                end
                ST_HIGH, ST_LOW: begin
                    if (!en_i) begin
                        state_q <= ST_IDLE;
                        sq_q    <= 1'b0;
                    end else if (fin) begin
                        state_q <= ST_IDLE;
                        sq_q    <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (bound) begin
                        act_m_q <= eff_m;
                        act_n_q <= eff_n;
                        act_b_q <= eff_b;
                        state_q <= st_start;
                        cnt_q   <= '0;
                        sq_q    <= start_hi;
                        if (pend && (act_b_q != '0)) begin
                            pcnt_q <= pcnt_nx;
                        end
                    end else if (hi_end) begin
                        state_q <= ST_LOW;
                        cnt_q   <= '0;
                        sq_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + C_ONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    sq_q    <= 1'b0;
                end
            endcase
        end
    end

    assign sq_o   = sq_q;
    assign busy_o = (state_q != ST_IDLE);
    assign done_o = done_q;

endmodule

// File: rtl/psqwg_multi.sv
// Multi-channel programmable square-wave generator top level.
// Replicates one independent channel per bit of the bundled buses.
module psqwg_multi
    import psqwg_multi_pkg::*;
#(
    parameter int T            = 20,
    parameter int UNIT_NS      = 100,
    parameter int CH           = 4,
    parameter int M_BITS       = 4,
    parameter int N_BITS       = 4,
    parameter int BURST_BITS   = 8,
    parameter int COUNTER_BITS = 7
) (
    input  logic          clk,
    input  logic          rst,
    psqwg_multi_if.slave  bus
);
    localparam int DIV = div_of(T, UNIT_NS);

    logic [CH-1:0] sq_w;
    logic [CH-1:0] busy_w;
    logic [CH-1:0] done_w;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        psqwg_chan #(
            .DIV          (DIV),
            .M_BITS       (M_BITS),
            .N_BITS       (N_BITS),
            .BURST_BITS   (BURST_BITS),
            .COUNTER_BITS (COUNTER_BITS)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .en_i     (bus.en[i]),
            .cfg_we_i (bus.cfg_we[i]),
            .m_i      (bus.m[i*M_BITS +: M_BITS]),
            .n_i      (bus.n[i*N_BITS +: N_BITS]),
            .burst_i  (bus.burst[i*BURST_BITS +: BURST_BITS]),
            .sq_o     (sq_w[i]),
            .busy_o   (busy_w[i]),
            .done_o   (done_w[i])
        );
    end

    assign bus.sq_wave = sq_w;
    assign bus.busy    = busy_w;
    assign bus.done    = done_w;

endmodule

// File: tb/tb_psqwg_multi.sv
// Directed self-checking bench for psqwg_multi (DIV = 5 clocks per unit).
// Channel 3 free-runs m=1,n=1 and is checked every cycle for interference.
module tb_psqwg_multi;
    import psqwg_multi_pkg::*;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    bit   run3   = 0;
    int   s3     = 0;

    psqwg_multi_if bus ();

    psqwg_multi dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d: got %b want %b", tag, cyc, obs, exp);
        end
    endtask

    // k = cycles since en was raised; first high sample at k=2.
    function automatic logic wave(input int k, input int hi, input int per);
        return (k >= 2) && (((k - 2) % per) < hi);
    endfunction

    function automatic logic rexp(input int k);
        if (k < 2)   return 1'b0;
        if (k <= 11) return 1'b1;
        if (k <= 21) return 1'b0;
        if (k <= 41) return 1'b1;
        if (k <= 51) return 1'b0;
        return (((k - 52) % 15) < 5);
    endfunction

    task automatic tick();
        int k;
        @(negedge clk);
        cyc++;
        if (run3) begin
            k = cyc - s3;
            chk("ch3_sq", bus.sq_wave[3], wave(k, 5, 10));
            chk("ch3_busy", bus.busy[3], k >= 2);
            chk("ch3_done", bus.done[3], 1'b0);
        end
    endtask

    task automatic cfg(input int ch, input int mv, input int nv, input int bv);
        bus.m[ch*4 +: 4]     = 4'(mv);
        bus.n[ch*4 +: 4]     = 4'(nv);
        bus.burst[ch*8 +: 8] = 8'(bv);
        bus.cfg_we[ch]       = 1'b1;
        tick();
        bus.cfg_we[ch]       = 1'b0;
    endtask

    initial begin
        int s, s0, s1, s2, k;
        if (!cfg_legal(20, 100, 4, 4, 7)) begin
            $fatal(1, "FAIL param_legal: default parameters illegal");
        end
        rst        = 1'b1;
        bus.en     = '0;
        bus.cfg_we = '0;
        bus.m      = '0;
        bus.n      = '0;
        bus.burst  = '0;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("rst_sq", bus.sq_wave[i], 1'b0);
            chk("rst_busy", bus.busy[i], 1'b0);
            chk("rst_done", bus.done[i], 1'b0);
        end
        rst = 1'b0;

        cfg(3, 1, 1, 0);
        bus.en[3] = 1'b1;
        s3   = cyc;
        run3 = 1'b1;

        cfg(0, 2, 3, 0);
        bus.en[0] = 1'b1;
        s = cyc;
        for (int i = 0; i < 55; i++) begin
            tick();
            k = cyc - s;
            chk("basic_sq", bus.sq_wave[0], wave(k, 10, 25));
            chk("basic_busy", bus.busy[0], k >= 2);
        end
        bus.en[0] = 1'b0;
        tick();
        chk("abort_en_sq", bus.sq_wave[0], 1'b0);
        chk("abort_en_busy", bus.busy[0], 1'b0);
        chk("abort_en_done", bus.done[0], 1'b0);

        cfg(1, 1, 1, 3);
        bus.en[1] = 1'b1;
        s = cyc;
        for (int i = 0; i < 40; i++) begin
            tick();
            k = cyc - s;
            chk("burst_sq", bus.sq_wave[1], (k < 32) && wave(k, 5, 10));
            chk("burst_busy", bus.busy[1], (k >= 2) && (k < 32));
            chk("burst_done", bus.done[1], k == 32);
        end
        bus.en[1] = 1'b0;
        tick();
        bus.en[1] = 1'b1;
        tick();
        chk("rearm_sq0", bus.sq_wave[1], 1'b0);
        tick();
        chk("rearm_sq1", bus.sq_wave[1], 1'b1);
        chk("rearm_busy", bus.busy[1], 1'b1);

        cfg(2, 2, 2, 0);
        bus.en[2] = 1'b1;
        s = cyc;
        for (int kk = 1; kk <= 75; kk++) begin
            if (kk == 6) begin
                bus.m[8 +: 4]  = 4'd4;
                bus.cfg_we[2] = 1'b1;
            end else if (kk == 52) begin
                bus.m[8 +: 4]  = 4'd1;
                bus.cfg_we[2] = 1'b1;
            end else begin
                bus.cfg_we[2] = 1'b0;
            end
            tick();
            chk("reconf_sq", bus.sq_wave[2], rexp(cyc - s));
        end
        bus.cfg_we[2] = 1'b0;
        bus.en[2]     = 1'b0;

        bus.en[0] = 1'b0;
        cfg(0, 0, 3, 0);
        bus.en[0] = 1'b1;
        s = cyc;
        for (int i = 0; i < 30; i++) begin
            tick();
            k = cyc - s;
            chk("m0_sq", bus.sq_wave[0], 1'b0);
            chk("m0_busy", bus.busy[0], k >= 2);
        end
        bus.en[0] = 1'b0;
        cfg(0, 3, 0, 0);
        bus.en[0] = 1'b1;
        s = cyc;
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("n0_sq", bus.sq_wave[0], (cyc - s) >= 2);
        end
        bus.en[0] = 1'b0;

        bus.en[1] = 1'b0;
        cfg(1, 0, 0, 2);
        bus.en[1] = 1'b1;
        s = cyc;
        for (int i = 0; i < 30; i++) begin
            tick();
            k = cyc - s;
            chk("zz_sq", bus.sq_wave[1], 1'b0);
            chk("zz_busy", bus.busy[1], k >= 2);
            chk("zz_done", bus.done[1], 1'b0);
        end
        bus.en[1] = 1'b0;
        tick();

        bus.m[0 +: 4]      = 4'd1;
        bus.n[0 +: 4]      = 4'd2;
        bus.m[4 +: 4]      = 4'd3;
        bus.n[4 +: 4]      = 4'd1;
        bus.m[8 +: 4]      = 4'd2;
        bus.n[8 +: 4]      = 4'd4;
        bus.burst[0 +: 24] = '0;
        bus.cfg_we[2:0]    = 3'b111;
        tick();
        bus.cfg_we[2:0]    = 3'b000;
        bus.en[0] = 1'b1;
        s0 = cyc;
        tick();
        bus.en[1] = 1'b1;
        s1 = cyc;
        tick();
        tick();
        bus.en[2] = 1'b1;
        s2 = cyc;
        for (int i = 0; i < 60; i++) begin
            tick();
            chk("multi_sq0", bus.sq_wave[0], wave(cyc - s0, 5, 15));
            chk("multi_sq1", bus.sq_wave[1], wave(cyc - s1, 15, 20));
            chk("multi_sq2", bus.sq_wave[2], wave(cyc - s2, 10, 30));
        end

        run3   = 1'b0;
        rst    = 1'b1;
        bus.en = '0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("abort_rst_sq", bus.sq_wave[i], 1'b0);
            chk("abort_rst_busy", bus.busy[i], 1'b0);
            chk("abort_rst_done", bus.done[i], 1'b0);
        end
        rst = 1'b0;

        bus.en[0] = 1'b1;
        tick();
        tick();
        chk("shadow_clr_sq", bus.sq_wave[0], 1'b0);
        chk("shadow_clr_busy", bus.busy[0], 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
